// File: rtl/axil_dmem.sv
// axil_dmem: AXI-Lite slave data memory with independent write and read FSMs
module axil_dmem #(
    parameter int XLEN      = 32,
    parameter int DMADDRLEN = 32,
    parameter int DEPTH     = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_axi_awvalid,
    input  logic [DMADDRLEN-1:0] s_axi_awaddr,
    output logic                 s_axi_awready,
    input  logic                 s_axi_wvalid,
    input  logic [XLEN-1:0]      s_axi_wdata,
    input  logic [XLEN/8-1:0]    s_axi_wstrb,
    output logic                 s_axi_wready,
    output logic                 s_axi_bvalid,
    output logic [1:0]           s_axi_bresp,
    input  logic                 s_axi_bready,
    input  logic                 s_axi_arvalid,
    input  logic [DMADDRLEN-1:0] s_axi_araddr,
    output logic                 s_axi_arready,
    output logic                 s_axi_rvalid,
    output logic [XLEN-1:0]      s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    input  logic                 s_axi_rready
);
    localparam int IW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wst_t;
    typedef enum logic {R_IDLE, R_RESP} rst_t;

    wst_t                 wst_q, wst_d;
    rst_t                 rst_q, rst_d;
    logic                 rdy_q;
    logic [DMADDRLEN-1:0] haddr_q, haddr_d;
    logic [XLEN-1:0]      hdata_q, hdata_d;
    logic [NB-1:0]        hstrb_q, hstrb_d;
    logic [1:0]           bresp_q, bresp_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [XLEN-1:0]      mem [DEPTH];

    logic                 aw_hs, w_hs, ar_hs, commit, we;
    logic [DMADDRLEN-1:0] caddr;
    logic [XLEN-1:0]      cdata;
    logic [NB-1:0]        cstrb;

    function automatic logic oor(input logic [DMADDRLEN-1:0] a);
        return |(a >> (IW + 2));
    endfunction

    function automatic logic [IW-1:0] widx(input logic [DMADDRLEN-1:0] a);
        return a[IW+1:2];
    endfunction

    // Handshake decode; readies are held off until one cycle after reset releases
    always_comb begin
        s_axi_awready = rdy_q && (wst_q == W_IDLE || wst_q == W_HAVE_D);
        s_axi_wready  = rdy_q && (wst_q == W_IDLE || wst_q == W_HAVE_A);
        s_axi_arready = rdy_q && (rst_q == R_IDLE);
        s_axi_bvalid  = (wst_q == W_RESP);
        s_axi_rvalid  = (rst_q == R_RESP);
        s_axi_bresp   = bresp_q;
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = rresp_q;
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        ar_hs         = s_axi_arvalid && s_axi_arready;
    end

    // Write FSM next state: collect address and data in either order, then respond
    always_comb begin
        wst_d = wst_q;
        case (wst_q)
            W_IDLE:   wst_d = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_A : w_hs ? W_HAVE_D : W_IDLE;
            W_HAVE_A: wst_d = w_hs ? W_RESP : W_HAVE_A;
            W_HAVE_D: wst_d = aw_hs ? W_RESP : W_HAVE_D;
            W_RESP:   wst_d = s_axi_bready ? W_IDLE : W_RESP;
            default:  wst_d = W_IDLE;
        endcase
    end

    // Write datapath: whichever half arrives this cycle comes from the bus, the other from the holding regs
    always_comb begin
        haddr_d = aw_hs ? s_axi_awaddr : haddr_q;
        hdata_d = w_hs ? s_axi_wdata : hdata_q;
        hstrb_d = w_hs ? s_axi_wstrb : hstrb_q;
        caddr   = aw_hs ? s_axi_awaddr : haddr_q;
        cdata   = w_hs ? s_axi_wdata : hdata_q;
        cstrb   = w_hs ? s_axi_wstrb : hstrb_q;
        commit  = (wst_d == W_RESP) && (wst_q != W_RESP);
        we      = commit && rstn && !oor(caddr);
        bresp_d = commit ? (oor(caddr) ? 2'b10 : 2'b00) : bresp_q;
    end

    // Read FSM next state and response capture; memory is sampled before any same-edge write lands
    always_comb begin
        rst_d   = (rst_q == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (s_axi_rready ? R_IDLE : R_RESP);
        rdata_d = ar_hs ? (oor(s_axi_araddr) ? '0 : mem[widx(s_axi_araddr)]) : rdata_q;
        rresp_d = ar_hs ? (oor(s_axi_araddr) ? 2'b10 : 2'b00) : rresp_q;
    end

    // State and response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        rdy_q   <= rstn;
        haddr_q <= haddr_d;
        hdata_q <= hdata_d;
        hstrb_q <= hstrb_d;
        if (!rstn) begin
            wst_q   <= W_IDLE;
            rst_q   <= R_IDLE;
            bresp_q <= 2'b00;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            wst_q   <= wst_d;
            rst_q   <= rst_d;
            bresp_q <= bresp_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // Byte-lane write into the unreset memory array
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < NB; i++)
                if (cstrb[i])
                    mem[widx(caddr)][8*i +: 8] <= cdata[8*i +: 8];
    end
endmodule

// File: doc/axil_dmem.md
AXIL_DMEM -- requirements
Module: axil_dmem

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter DMADDRLEN, default 32, byte address width.
REQ-003 Parameter DEPTH, default 1024, number of XLEN-bit words; power of two.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 s_axi  if_axi_lite.S  AXI-Lite slave port; the block consumes the master side driven by the core memory unit.
REQ-007 s_axi.awvalid/awaddr  input  1/DMADDRLEN  write address; s_axi.awready output 1.
REQ-008 s_axi.wvalid/wdata/wstrb  input  1/XLEN/XLEN/8  write data and byte strobes; s_axi.wready output 1.
REQ-009 s_axi.bvalid/bresp  output  1/2  write response; s_axi.bready input 1.
REQ-010 s_axi.arvalid/araddr  input  1/DMADDRLEN  read address; s_axi.arready output 1.
REQ-011 s_axi.rvalid/rdata/rresp  output  1/XLEN/2  read response; s_axi.rready input 1.

Function
REQ-012 Word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored; address out of range when any bit above log2(DEPTH)+1 is nonzero.
REQ-013 Write FSM states: W_IDLE, W_HAVE_A (address held, awaiting data), W_HAVE_D (data held, awaiting address), W_RESP.
REQ-014 awready = 1 in W_IDLE and W_HAVE_D only; wready = 1 in W_IDLE and W_HAVE_A only.
REQ-015 W_IDLE: AW and W handshake same cycle -> W_RESP; AW only -> W_HAVE_A; W only -> W_HAVE_D.
REQ-016 W_HAVE_A + W handshake, or W_HAVE_D + AW handshake -> W_RESP.
REQ-017 On the edge entering W_RESP, in-range write updates each byte lane i where wstrb[i]=1; lanes with wstrb[i]=0 unchanged; bvalid rises same edge.
REQ-018 bresp = 2'b00 (OKAY) in range; 2'b10 (SLVERR) out of range, memory untouched.
REQ-019 W_RESP holds bvalid/bresp stable until bready=1; on bvalid&bready -> W_IDLE; one outstanding write maximum.
REQ-020 Read FSM states: R_IDLE, R_RESP; arready = 1 in R_IDLE only.
REQ-021 AR handshake: memory sampled at that edge, rvalid=1 next cycle (latency 1), -> R_RESP.
REQ-022 rdata = addressed word, rresp = OKAY in range; rdata = 0, rresp = SLVERR out of range.
REQ-023 R_RESP holds rvalid/rdata/rresp stable until rready=1; on rvalid&rready -> R_IDLE; next AR accepted no earlier than the following cycle.
REQ-024 Read and write FSMs independent; simultaneous AR handshake and write commit to same word: read returns pre-write data.
REQ-025 wstrb = 0 in range: no bytes change, bresp OKAY.

Reset
REQ-026 While rstn=0 at a rising edge: both FSMs -> idle; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-027 awready, wready, arready = 0 in the cycle rstn=0 is sampled, 1 from the first cycle after rstn=1 is sampled.
REQ-028 Reset mid-transaction discards held address/data and pending responses; no memory write occurs from discarded state.
REQ-029 Memory array contents not reset.

Verification
REQ-030 AW 0x10 + W 0xDEADBEEF wstrb 0xF same cycle -> bvalid next cycle, bresp 0; AR 0x10 -> rvalid 1 cycle later, rdata 0xDEADBEEF, rresp 0.
REQ-031 Word 0x10 = 0xDEADBEEF; write 0x11223344 wstrb 0x5 -> read 0xDE22BE44.
REQ-032 W first, AW 3 cycles later; then AW first, W 2 cycles later -> each single commit, awready/wready low in holding state, bvalid held 4 cycles with bready=0.
REQ-033 AR 0x0000_1000 (DEPTH 1024) -> rdata 0, rresp 2'b10; AW same + W -> bresp 2'b10, word 0 unchanged.
REQ-034 Word 0x20 = 0x1; AR 0x20 on same edge as commit of 0x2 to 0x20 -> rdata 0x1; next read 0x2.
REQ-035 rstn=0 while in W_HAVE_A and R_RESP -> bvalid=rvalid=0 next cycle, no write, readies high the cycle after rstn returns 1.
